// File: rtl/stub_capture_pkg.sv
// Shared definitions for the stub capture buffer: FSM encoding, register map, CTRL bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stub_capture_pkg;

    // Capture FSM encoding (value is visible in STATUS[13:12])
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_FULL    = 2'd3;

    // Register map, decoded from io_addr[4:0]
    localparam logic [4:0] ADDR_DATA_LO = 5'h00;
    localparam logic [4:0] ADDR_DATA_HI = 5'h01;
    localparam logic [4:0] ADDR_STATUS  = 5'h02;
    localparam logic [4:0] ADDR_CTRL    = 5'h03;
    localparam logic [4:0] ADDR_DROPS   = 5'h04;

    // CTRL write bit positions
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_FLUSH_BIT = 2;

    localparam int STUB_W  = 36;
    localparam int BX_W    = 3;
    localparam int ENTRY_W = BX_W + STUB_W;   // 39
    localparam int DROP_W  = 16;

    // One buffered entry: bunch-crossing tag above the stub word
    typedef struct packed {
        logic [BX_W-1:0]   bx;
        logic [STUB_W-1:0] data;
    } entry_t;

    // Drop counter increment that sticks at all-ones
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stub_capture_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured stub entries.
// Latency: a push is visible at head and in count the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; clear empties it.
module capture_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 39
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents are not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stub_capture.sv
// Arms on a CTRL write, captures {BX, stub} words from first_clk onward, read back over the I/O bus.
// Latency: entry counted one cycle after capture; register reads acknowledged one cycle after rd_op.
// Backpressure: none upstream; words arriving while full are dropped and counted.
module stub_capture
    import stub_capture_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_proc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic [2:0]        BX,
    input  logic              first_clk,
    input  logic              io_sel,
    input  logic              io_sync,
    input  logic              io_rd_en,
    input  logic              io_wr_en,
    input  logic [23:0]       io_addr,
    input  logic [31:0]       io_wr_data,
    output logic [31:0]       io_rd_data,
    output logic              io_rd_ack
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);

    logic               rd_op;
    logic               wr_op;
    logic [4:0]         addr;
    logic               wr_ctrl;
    logic               ctrl_arm;
    logic               ctrl_stop;
    logic               ctrl_flush;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               push;
    logic               pop;
    logic               drop;
    entry_t             entry_in;
    entry_t             head;
    logic [COUNT_W-1:0] fifo_count;
    logic [COUNT_W-1:0] count_nxt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               overflow;
    logic [DROP_W-1:0]  drops;
    logic [6:0]         shadow;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign rd_op   = io_sync & io_sel & io_rd_en;
    assign wr_op   = io_sync & io_sel & io_wr_en;
    assign addr    = io_addr[4:0];
    assign wr_ctrl = wr_op & (addr == ADDR_CTRL);

    assign ctrl_arm   = wr_ctrl & io_wr_data[CTRL_ARM_BIT];
    assign ctrl_stop  = wr_ctrl & io_wr_data[CTRL_STOP_BIT];
    assign ctrl_flush = wr_ctrl & io_wr_data[CTRL_FLUSH_BIT];

    assign unused_bits = ^{io_addr[23:5], io_wr_data[31:3]};

    assign entry_in.bx   = BX;
    assign entry_in.data = STUB_W'(data_in);

    // A stop or flush in the same cycle kills the push rather than counting it as a drop
    assign push = (state == ST_CAPTURE) & valid_in & en_proc & ~fifo_full & ~ctrl_stop & ~ctrl_flush;
    assign drop = valid_in & en_proc & ~ctrl_stop & ~ctrl_flush &
                  ((state == ST_FULL) | ((state == ST_CAPTURE) & fifo_full));
    assign pop  = rd_op & (addr == ADDR_DATA_LO) & ~fifo_empty;

    capture_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (ctrl_flush),
        .push  (push),
        .pop   (pop),
        .din   (entry_in),
        .head  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Occupancy one cycle ahead, used to enter FULL as the last slot is written
    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
    end

    // Capture FSM next state; flush/stop override everything, arm only from IDLE
    always_comb begin
        state_nxt = state;
        if (ctrl_flush || ctrl_stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (ctrl_arm)               state_nxt = ST_ARMED;
                ST_ARMED:   if (first_clk && en_proc)   state_nxt = ST_CAPTURE;
                ST_CAPTURE: if (count_nxt == FULL_CNT)  state_nxt = ST_FULL;
                ST_FULL:    if (pop)                    state_nxt = ST_CAPTURE;
                default:                                state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM, overflow flag, drop counter and popped-entry shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            overflow <= 1'b0;
            drops    <= '0;
            shadow   <= '0;
        end else begin
            state <= state_nxt;
            if (ctrl_flush) begin
                overflow <= 1'b0;
                drops    <= '0;
                shadow   <= '0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                    drops    <= sat_inc(drops);
                end
                if (pop) begin
                    shadow <= {head.bx, head.data[35:32]};
                end
            end
        end
    end

    // Register read multiplexer, sampled into io_rd_data on rd_op
    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DATA_LO: rd_mux = fifo_empty ? 32'd0 : head.data[31:0];
            ADDR_DATA_HI: rd_mux = {25'd0, shadow};
            ADDR_STATUS: begin
                rd_mux[6:0]   = 7'(fifo_count);
                rd_mux[8]     = fifo_empty;
                rd_mux[9]     = fifo_full;
                rd_mux[10]    = overflow;
                rd_mux[13:12] = state;
            end
            ADDR_DROPS:   rd_mux = {16'd0, drops};
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data and one-cycle acknowledge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_rd_ack  <= 1'b0;
            io_rd_data <= '0;
        end else begin
            io_rd_ack <= rd_op;
            if (rd_op) begin
                io_rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_stub_capture.sv
// Bench for stub_capture: register reads checked through an expected-value queue.
// Latency: each read is expected to ack exactly one cycle after rd_op.
// Backpressure: none; reads wait a bounded number of cycles for the ack.
module tb_stub_capture;

    logic        clk;
    logic        reset;
    logic        en_proc;
    logic [35:0] data_in;
    logic        valid_in;
    logic [2:0]  BX;
    logic        first_clk;
    logic        io_sel;
    logic        io_sync;
    logic        io_rd_en;
    logic        io_wr_en;
    logic [23:0] io_addr;
    logic [31:0] io_wr_data;
    logic [31:0] io_rd_data;
    logic        io_rd_ack;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];

    stub_capture #(.DEPTH(64), .DATA_W(36)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_proc    (en_proc),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .BX         (BX),
        .first_clk  (first_clk),
        .io_sel     (io_sel),
        .io_sync    (io_sync),
        .io_rd_en   (io_rd_en),
        .io_wr_en   (io_wr_en),
        .io_addr    (io_addr),
        .io_wr_data (io_wr_data),
        .io_rd_data (io_rd_data),
        .io_rd_ack  (io_rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one rd_op; the expected value is queued now and popped when the ack appears
    task automatic io_read(input logic [23:0] addr, input logic [31:0] exp, input string nm);
        bit got;
        logic [31:0] e;
        string n;
        io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1; io_addr = addr;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        @(posedge clk); #1;
        io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk({nm, "/ack"}, {31'd0, io_rd_ack}, 32'd1);
        got = 1'b0;
        for (int w = 0; w < 4 && !got; w++) begin
            if (io_rd_ack) begin
                got = 1'b1;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                chk(n, io_rd_data, e);
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s/timeout: io_rd_ack never rose within 4 cycles, required after 1", nm);
            exp_q.delete();
            nm_q.delete();
        end
        @(posedge clk); #1;
        chk({nm, "/ack_pulse"}, {31'd0, io_rd_ack}, 32'd0);
    endtask

    task automatic io_write(input logic [23:0] addr, input logic [31:0] d);
        io_sel = 1'b1; io_sync = 1'b1; io_wr_en = 1'b1; io_addr = addr; io_wr_data = d;
        @(posedge clk); #1;
        io_sel = 1'b0; io_sync = 1'b0; io_wr_en = 1'b0; valid_in = 1'b0;
    endtask

    task automatic push_word(input logic [35:0] d, input logic [2:0] bx);
        data_in = d; BX = bx; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic pulse_first(input logic with_valid);
        first_clk = 1'b1; valid_in = with_valid; data_in = 36'h0_0000DEAD; BX = 3'd7;
        @(posedge clk); #1;
        first_clk = 1'b0; valid_in = 1'b0;
    endtask

    initial begin
        vecs[0]  = {24'h000002, 32'h00002003};
        vecs[1]  = {24'h100002, 32'h00002003};
        vecs[2]  = {24'h000003, 32'h00000000};
        vecs[3]  = {24'h000005, 32'h00000000};
        vecs[4]  = {24'h000004, 32'h00000000};
        vecs[5]  = {24'h000000, 32'h00000001};
        vecs[6]  = {24'h000001, 32'h0000005A};
        vecs[7]  = {24'h000002, 32'h00002002};
        vecs[8]  = {24'h000020, 32'h00000002};
        vecs[9]  = {24'h000000, 32'h00000003};
        vecs[10] = {24'h000001, 32'h0000005A};
        vecs[11] = {24'h000000, 32'h00000000};
        vecs[12] = {24'h000002, 32'h00002100};
        vecs[13] = {24'h000001, 32'h0000005A};

        reset = 1'b1; en_proc = 1'b0; data_in = '0; valid_in = 1'b0; BX = '0;
        first_clk = 1'b0; io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0;
        io_wr_en = 1'b0; io_addr = '0; io_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/rd_ack", {31'd0, io_rd_ack}, 32'd0);
        chk("reset/rd_data", io_rd_data, 32'd0);
        reset = 1'b0;
        en_proc = 1'b1;
        @(posedge clk); #1;

        // Reset state
        io_read(24'h000002, 32'h00000100, "reset_status");
        io_read(24'h000004, 32'h00000000, "reset_drops");

        // Ungated strobes: no sync means no read
        io_sel = 1'b1; io_rd_en = 1'b1; io_addr = 24'h000002;
        @(posedge clk); #1;
        io_sel = 1'b0; io_rd_en = 1'b0;
        @(negedge clk);
        chk("nosync/ack", {31'd0, io_rd_ack}, 32'd0);
        @(posedge clk); #1;

        // Arm, first_clk with valid (not pushed), a disabled word, then three words
        io_write(24'h000003, 32'h1);
        io_read(24'h000002, 32'h00001100, "armed_status");
        pulse_first(1'b1);
        en_proc = 1'b0;
        push_word(36'hF_FFFFFFFF, 3'd6);
        en_proc = 1'b1;
        for (int i = 1; i <= 3; i++) push_word({4'hA, 32'(i)}, 3'd5);
        for (int i = 0; i < 14; i++) io_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        io_write(24'h000013, 32'h4);
        io_read(24'h000002, 32'h00002100, "unmapped_write");

        // Flush, then fill past capacity
        io_write(24'h000003, 32'h4);
        io_read(24'h000002, 32'h00000100, "flush_status");
        io_read(24'h000001, 32'h00000000, "flush_shadow");
        io_write(24'h000003, 32'h1);
        pulse_first(1'b0);
        for (int i = 0; i < 70; i++) push_word({4'h1, 32'h100 + 32'(i)}, 3'(i));
        io_read(24'h000002, 32'h00003640, "full_status");
        io_read(24'h000004, 32'h00000006, "full_drops");
        io_sync = 1'b1; io_wr_en = 1'b1; io_addr = 24'h000003; io_wr_data = 32'h4;
        @(posedge clk); #1;
        io_sync = 1'b0; io_wr_en = 1'b0;
        io_read(24'h000002, 32'h00003640, "nosel_write");

        // Pop while FULL with valid high: dropped that cycle, then the next word fits
        valid_in = 1'b1; data_in = {4'h2, 32'hCAFE0000}; BX = 3'd3;
        io_read(24'h000000, 32'h00000100, "full_pop");
        io_read(24'h000002, 32'h0000243F, "after_full_pop");
        push_word({4'h2, 32'hCAFE0000}, 3'd3);
        io_read(24'h000002, 32'h00003640, "refill_status");
        io_read(24'h000004, 32'h00000007, "refill_drops");
        io_read(24'h000001, 32'h00000001, "full_pop_hi");

        // Stop+flush+arm during CAPTURE with a push in the same cycle
        io_read(24'h000000, 32'h00000101, "second_pop");
        io_read(24'h000001, 32'h00000011, "second_pop_hi");
        valid_in = 1'b1; data_in = 36'h5_55555555; BX = 3'd2;
        io_write(24'h000003, 32'h7);
        io_read(24'h000002, 32'h00000100, "ctrl7_status");
        io_read(24'h000004, 32'h00000000, "ctrl7_drops");
        io_read(24'h000001, 32'h00000000, "ctrl7_shadow");
        io_read(24'h000000, 32'h00000000, "ctrl7_empty_lo");

        // Stop keeps entries; stop beats arm; arm from IDLE afterwards
        io_write(24'h000003, 32'h1);
        pulse_first(1'b0);
        push_word({4'h3, 32'h10}, 3'd2);
        push_word({4'h3, 32'h11}, 3'd2);
        valid_in = 1'b1; data_in = 36'h6_66666666; BX = 3'd1;
        io_write(24'h000003, 32'h2);
        io_read(24'h000002, 32'h00000002, "stop_status");
        io_write(24'h000003, 32'h3);
        io_read(24'h000002, 32'h00000002, "stop_over_arm");
        io_write(24'h000003, 32'h1);
        io_read(24'h000002, 32'h00001002, "rearm_status");
        io_read(24'h000000, 32'h00000010, "stop_pop_lo");
        io_read(24'h000001, 32'h00000023, "stop_pop_hi");
        io_write(24'h000003, 32'h4);
        io_read(24'h000002, 32'h00000100, "flush2_status");

        // Simultaneous push and pop, then reset mid-capture
        io_write(24'h000003, 32'h1);
        pulse_first(1'b0);
        for (int i = 0; i < 10; i++) push_word({4'h4, 32'h200 + 32'(i)}, 3'd1);
        io_read(24'h000002, 32'h0000200A, "ten_status");
        valid_in = 1'b1; data_in = {4'h4, 32'h20A}; BX = 3'd1;
        io_read(24'h000000, 32'h00000200, "pushpop_lo");
        io_read(24'h000002, 32'h0000200A, "pushpop_status");
        io_read(24'h000001, 32'h00000014, "pushpop_hi");
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset/rd_data", io_rd_data, 32'd0);
        chk("async_reset/rd_ack", {31'd0, io_rd_ack}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        io_read(24'h000002, 32'h00000100, "post_reset_status");
        io_read(24'h000000, 32'h00000000, "post_reset_lo");
        io_read(24'h000001, 32'h00000000, "post_reset_hi");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
